packet_sample_unpacker: RTL
===========================

# packet_sample_unpacker

Downstream stage of `packet_reciever` in the UART offload path. It captures each completed packet and streams it out as fixed-width samples over a valid/ready handshake to the FFT input buffer. Samples leave in first-received-byte order. Packets that arrive while a previous packet is still streaming are dropped and flagged.

## Interface
- `PACKET_SIZE`, 16, packet length in bytes; must match the upstream receiver.
- `SAMPLE_WIDTH`, 16, output sample width in bits. It must be a multiple of 8 and divide `8*PACKET_SIZE`; otherwise elaboration fails via `$error`.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `packet` in `8*PACKET_SIZE`: receiver packet. The first-received byte sits at `[8*PACKET_SIZE-1 -: 8]`.
- `packet_ready` in 1: receiver ready level. Its rising edge marks a new packet.
- `sample_data` out `SAMPLE_WIDTH`: current sample.
- `sample_valid` out 1: `sample_data` is valid.
- `sample_ready` in 1: consumer accepts the sample.
- `sample_last` out 1: high with the final sample of a packet.
- `busy` out 1: high while a packet is being streamed.
- `overrun` out 1: one-cycle pulse when a packet is dropped.

## Operation
- N = `8*PACKET_SIZE/SAMPLE_WIDTH` samples per packet. The counter is `$clog2(N)+1` bits wide.
- Edge detect: register `rdy_q <= packet_ready`. `new_pkt = packet_ready & ~rdy_q`.
- States: IDLE, STREAM.
- IDLE:
  - On `new_pkt`: load the shift register with `packet`, clear the count, go to STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - `sample_data` = shift register `[8*PACKET_SIZE-1 -: SAMPLE_WIDTH]`, unmodified. The first-received byte is the sample MSB.
  - A handshake occurs when `sample_valid & sample_ready`. On each handshake: shift left by `SAMPLE_WIDTH` and increment the count.
  - `sample_last` = (count == N-1).
  - Handshake on the last sample with no `new_pkt`: go to IDLE.
- Simultaneous events:
  - `new_pkt` in the same cycle as the final handshake: the new packet is accepted. Reload, clear the count, remain in STREAM, and do not pulse `overrun`.
  - `new_pkt` during STREAM at any other time: the packet is dropped, `overrun` pulses for 1 cycle, and the stream continues unaffected.
- Output stability: while `sample_valid=1` and `sample_ready=0`, `sample_data` and `sample_last` hold stable.
- `busy` equals `sample_valid` (state == STREAM).

## Timing
- Reset values:
  - `sample_valid`, `sample_last`, `busy`, `overrun` = 0.
  - `sample_data` = 0; the shift register and count are cleared.
  - `rdy_q` = 1, so a `packet_ready` held high through reset release is never taken as a new packet.
- Reset mid-stream: remaining samples are discarded and the block is in IDLE the next cycle.
- Latency:
  - `new_pkt` seen at edge k: `sample_valid=1` and the first sample are presented after edge k (1 cycle).
  - Each subsequent sample appears 1 cycle after its predecessor's handshake.
- Throughput: with `sample_ready` held high, N samples take N cycles. The next packet can begin on the cycle of the last handshake.
- `overrun` is registered; it is high for exactly the cycle after the dropping edge.

## Configuration
- `UNPACK_OVERRUN_CNT_EN`:
  - Defined: adds output `overrun_count` [7:0]. It increments on every `overrun` pulse, saturates at 255, and resets to 0.
  - Undefined: the port and counter are absent. The `overrun` pulse is unchanged.

## Test plan
- Basic stream:
  - Stimulus: `PACKET_SIZE=4`, `SAMPLE_WIDTH=16`, `packet=32'h1234_ABCD`, `packet_ready` 0→1, `sample_ready=1`.
  - Response: 0x1234 with `last=0`, then 0xABCD with `last=1`, then `busy=0`.
- Backpressure:
  - Stimulus: same packet, `sample_ready` low for 3 cycles.
  - Response: 0x1234 held stable with `valid=1`. Exactly 2 handshakes occur total; no duplicate or lost samples.
- Overrun:
  - Stimulus: second `packet_ready` edge with `packet=32'hFFFF_0000` while the first sample is stalled.
  - Response: `overrun` pulses once (`overrun_count`=1 if enabled). The output is still 0x1234 then 0xABCD.
- Back-to-back:
  - Stimulus: new edge with `32'h0001_0002` in the same cycle as the 0xABCD handshake.
  - Response: no overrun; 0x0001 appears the next cycle, then 0x0002 with `last=1`.
- Reset mid-stream:
  - Stimulus: `rst_n=0` for 1 cycle after the 0x1234 handshake.
  - Response: `valid=0`, `busy=0`, no 0xABCD emitted.
  - Stimulus: `packet_ready` held high across reset release.
  - Response: no capture.
- Width check:
  - Stimulus: `PACKET_SIZE=15`, `SAMPLE_WIDTH=8`, packet "this is a test ".
  - Response: 15 bytes 't','h','i',… out in order, `last` with ' '.

Source files
------------

// File: rtl/packet_sample_unpacker_if.sv
// Sample stream interface between packet_sample_unpacker and its consumer
// (the FFT input buffer).
//   sample_data  : current sample, first-received byte in the MSBs
//   sample_valid : sample_data is valid
//   sample_ready : the consumer accepts the sample this cycle
//   sample_last  : final sample of a packet
// A transfer takes place on every rising edge where sample_valid & sample_ready.
// The master modport belongs to the producer. The slave modport belongs to the consumer.
interface packet_sample_unpacker_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    sample_last;

  modport master (
    output sample_data,
    output sample_valid,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    input  sample_last,
    output sample_ready
  );
endinterface

// File: rtl/packet_sample_unpacker.sv
// packet_sample_unpacker
// This block captures each completed receiver packet. It then streams the packet out as
// SAMPLE_WIDTH-bit samples, beginning with the first-received byte. A packet that arrives
// while an earlier packet is still streaming is dropped, and overrun pulses.
//
// Parameters:
//   PACKET_SIZE  : packet length in bytes
//   SAMPLE_WIDTH : sample width in bits. It must be a multiple of 8 and must divide 8*PACKET_SIZE.
// Ports:
//   clk, rst_n    : clock and synchronous active-low reset
//   packet        : receiver packet. The first-received byte is at the MSB end.
//   packet_ready  : receiver ready level. A rising edge marks a new packet.
//   smp           : sample stream (master modport)
//   busy          : a packet is streaming (equal to sample_valid)
//   overrun       : one-cycle pulse when a packet is dropped
//   overrun_count : saturating 8-bit count of overrun pulses. This port exists only when
//                   UNPACK_OVERRUN_CNT_EN is defined.
module packet_sample_unpacker #(
  parameter int PACKET_SIZE  = 16,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*PACKET_SIZE-1:0] packet,
  input  logic                     packet_ready,
  packet_sample_unpacker_if.master smp,
  output logic                     busy,
`ifdef UNPACK_OVERRUN_CNT_EN
  output logic [7:0]               overrun_count,
`endif
  output logic                     overrun
);

  localparam int PW = 8 * PACKET_SIZE;
  localparam int N  = PW / SAMPLE_WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((SAMPLE_WIDTH % 8) != 0 || (PW % SAMPLE_WIDTH) != 0) begin : g_bad_width
    $error("packet_sample_unpacker: SAMPLE_WIDTH must be a multiple of 8 and divide 8*PACKET_SIZE");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q;
  logic            overrun_q, overrun_d;
  logic            new_pkt;
  logic            hs;
  logic            last;

  assign new_pkt = packet_ready & ~rdy_q;
  assign hs      = (state_q == STREAM) & smp.sample_ready;
  assign last    = (state_q == STREAM) & (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_pkt) begin
          shreg_d = packet;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          shreg_d = shreg_q << SAMPLE_WIDTH;
          cnt_d   = cnt_q + CW'(1);
        end
        if (hs && last) begin
          // A packet that arrives on the final handshake is accepted. It is not dropped.
          if (new_pkt) begin
            shreg_d = packet;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (new_pkt) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      // Reset to 1 so that a ready level held high through reset release is not taken as a new packet.
      rdy_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      rdy_q     <= packet_ready;
      overrun_q <= overrun_d;
    end
  end

  // The register shifts in zeros. So sample_data returns to 0 once a packet has fully drained.
  assign smp.sample_data  = shreg_q[PW-1 -: SAMPLE_WIDTH];
  assign smp.sample_valid = (state_q == STREAM);
  assign smp.sample_last  = last;
  assign busy             = (state_q == STREAM);
  assign overrun          = overrun_q;

`ifdef UNPACK_OVERRUN_CNT_EN
  logic [7:0] ovc_q, ovc_d;

  // The counter steps on the same edge that raises overrun. So the count and the pulse appear together.
  always_comb begin
    ovc_d = ovc_q;
    if (overrun_d && ovc_q != 8'hFF) ovc_d = ovc_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovc_q <= '0;
    else        ovc_q <= ovc_d;
  end

  assign overrun_count = ovc_q;
`endif

endmodule
